// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: digest word count, writeback FSM states and a digest word selector.
package sha1_pkg;

  localparam int unsigned SHA1_NUM_WORDS = 5;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CMP,
    DONE
  } wb_state_t;

  // H0 is the most significant word of the 160-bit digest.
  function automatic logic [31:0] sha1_word(input logic [159:0] hash, input logic [2:0] idx);
    logic [31:0] w;
    unique case (idx)
      3'd0:    w = hash[159:128];
      3'd1:    w = hash[127:96];
      3'd2:    w = hash[95:64];
      3'd3:    w = hash[63:32];
      default: w = hash[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha1_rise_detect.sv
// Rising-edge detector on a level input; the history flop resets high so a level
// already asserted when reset releases is not mistaken for a new edge.
module sha1_rise_detect (
  input  logic clk,
  input  logic nreset,
  input  logic level,
  output logic rise
);

  logic done_q;
  logic done_d;

  always_comb begin
    done_d = level;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done_d;
    end
  end

  assign rise = level & ~done_q;

endmodule

// File: rtl/sha1_hash_writeback.sv
// Captures the SHA-1 digest on a rising hash_done and writes it big-endian to dpsram port B.
// Build with SHA1_WB_COMPARE_EN defined to read back an expected digest and report match.
module sha1_hash_writeback
  import sha1_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = SHA1_NUM_WORDS
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                hash_done,
  input  logic [159:0]        hash,
  input  logic [31:0]         result_addr,
  input  logic [31:0]         expected_addr,
  output logic                port_B_clk,
  output logic [ADDR_W-1:0]   port_B_addr,
  output logic [DATA_W-1:0]   port_B_data_in,
  input  logic [DATA_W-1:0]   port_B_data_out,
  output logic                port_B_we,
  output logic                wb_busy,
  output logic                wb_done,
  output logic                match
);

  localparam logic [2:0] LastIdx = 3'(NUM_WORDS - 1);

  wb_state_t         state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [159:0]      hash_q, hash_d;
  logic [ADDR_W-1:0] res_base_q, res_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rise;
  logic              trigger;

  sha1_rise_detect u_rise (
    .clk    (clk),
    .nreset (nreset),
    .level  (hash_done),
    .rise   (rise)
  );

  assign port_B_clk = clk;
  assign trigger    = rise && (state_q == IDLE);

`ifdef SHA1_WB_COMPARE_EN
  logic [ADDR_W-1:0] exp_base_q, exp_base_d;
  logic              match_q, match_d;
  logic              match_acc_q, match_acc_d;
  logic              unused_hi;
  assign unused_hi = ^{result_addr[31:ADDR_W], expected_addr[31:ADDR_W]};
`else
  logic              unused_in;
  assign unused_in = ^{result_addr[31:ADDR_W], expected_addr, port_B_data_out};
`endif

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hash_q      <= '0;
      res_base_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef SHA1_WB_COMPARE_EN
      exp_base_q  <= '0;
      match_q     <= 1'b0;
      match_acc_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hash_q      <= hash_d;
      res_base_q  <= res_base_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef SHA1_WB_COMPARE_EN
      exp_base_q  <= exp_base_d;
      match_q     <= match_d;
      match_acc_q <= match_acc_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hash_d     = hash_q;
    res_base_d = res_base_q;
`ifdef SHA1_WB_COMPARE_EN
    exp_base_d  = exp_base_q;
    match_d     = match_q;
    match_acc_d = match_acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = WRITE;
          idx_d      = '0;
          hash_d     = hash;
          res_base_d = result_addr[ADDR_W-1:0];
`ifdef SHA1_WB_COMPARE_EN
          exp_base_d  = expected_addr[ADDR_W-1:0];
          match_d     = 1'b0;
          match_acc_d = 1'b1;
`endif
        end
      end
      WRITE: begin
        if (idx_q == LastIdx) begin
          idx_d = '0;
`ifdef SHA1_WB_COMPARE_EN
          state_d = READ;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef SHA1_WB_COMPARE_EN
      READ: begin
        // Read data lags the address by one cycle, so compare the previous word.
        if (idx_q != 3'd0) begin
          match_acc_d = match_acc_q &
                        (port_B_data_out == sha1_word(hash_q, idx_q - 3'd1));
        end
        if (idx_q == LastIdx) begin
          state_d = CMP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      CMP: begin
        match_d = match_acc_q & (port_B_data_out == sha1_word(hash_q, LastIdx));
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; address and data hold their last driven value when idle.
  always_comb begin
    port_B_we      = 1'b0;
    port_B_addr    = addr_q;
    port_B_data_in = wdata_q;
    if (state_q == WRITE) begin
      port_B_we      = 1'b1;
      port_B_addr    = res_base_q + ADDR_W'(idx_q);
      port_B_data_in = sha1_word(hash_q, idx_q);
    end
`ifdef SHA1_WB_COMPARE_EN
    if (state_q == READ) begin
      port_B_addr = exp_base_q + ADDR_W'(idx_q);
    end
`endif
    addr_d  = port_B_addr;
    wdata_d = port_B_data_in;
    wb_busy = (state_q != IDLE);
    wb_done = (state_q == DONE);
`ifdef SHA1_WB_COMPARE_EN
    match   = match_q;
`else
    match   = 1'b0;
`endif
  end

endmodule
